// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port among N_REQ cache controllers, one request in flight.
// Define MEM_ARB_WATCHDOG_EN to add the response watchdog and the sticky timeout_err output.
module mem_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int LA_BITS   = 26,
  parameter int LINE_BITS = 512
`ifdef MEM_ARB_WATCHDOG_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_rw,
  input  logic [N_REQ*LA_BITS-1:0]   req_addr,
  input  logic [N_REQ*LINE_BITS-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [LINE_BITS-1:0]       resp_data,
  output logic                       mem_req_valid,
  output logic                       mem_req_rw,
  output logic [LA_BITS-1:0]         mem_req_addr,
  output logic [LINE_BITS-1:0]       mem_req_data,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  input  logic [LINE_BITS-1:0]       mem_resp_data,
  output logic                       busy
`ifdef MEM_ARB_WATCHDOG_EN
  , output logic                     timeout_err
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PW-1:0]          r_rr_ptr, r_owner;
  logic [PW-1:0]          w_off, w_winner, w_rr_nxt;
  logic [PW:0]            w_sum;
  logic [N_REQ-1:0]       w_req_rot;
  logic                   w_found, w_grant, w_resp_fire, w_abort, w_timeout;
  logic                   w_req_rw;
  logic [LA_BITS-1:0]     w_req_addr;
  logic [LINE_BITS-1:0]   w_req_data;
  logic                   r_mem_req_valid, r_rw;
  logic [LA_BITS-1:0]     r_addr;
  logic [LINE_BITS-1:0]   r_data, r_resp_data;
  logic [N_REQ-1:0]       r_resp_valid;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the offset of the winner.
  always_comb begin
    w_req_rot = N_REQ'({req_valid, req_valid} >> r_rr_ptr);
    w_found   = |req_valid;
    w_off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (w_req_rot[i]) w_off = PW'(i);
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (PW+1)'(N_REQ)) w_sum = w_sum - (PW+1)'(N_REQ);
    w_winner = w_sum[PW-1:0];
    w_rr_nxt = (w_winner == PW'(N_REQ - 1)) ? '0 : w_winner + PW'(1);
  end

  always_comb begin
    w_req_rw   = 1'b0;
    w_req_addr = '0;
    w_req_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_winner == PW'(i)) begin
        w_req_rw   = req_rw[i];
        w_req_addr = req_addr[i*LA_BITS +: LA_BITS];
        w_req_data = req_data[i*LINE_BITS +: LINE_BITS];
      end
  end

  // reset_n gates the accept pulse so every output is 0 while reset is held.
  assign w_grant = (r_state == S_IDLE) && reset_n && w_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = w_grant && (w_winner == PW'(i));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_resp_fire = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr        <= '0;
      r_owner         <= '0;
      r_rw            <= 1'b0;
      r_addr          <= '0;
      r_data          <= '0;
      r_mem_req_valid <= 1'b0;
      r_resp_valid    <= '0;
      r_resp_data     <= '0;
    end else begin
      r_mem_req_valid <= (w_state_nxt == S_ISSUE);
      r_resp_valid    <= '0;
      if (w_grant) begin
        r_rw     <= w_req_rw;
        r_addr   <= w_req_addr;
        r_data   <= w_req_data;
        r_owner  <= w_winner;
        r_rr_ptr <= w_rr_nxt;
      end
      if (w_resp_fire || w_abort) begin
        r_resp_valid[r_owner] <= 1'b1;
        r_resp_data           <= w_resp_fire ? mem_resp_data : '0;
      end
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic        r_timeout_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_grant)                 r_wd_cnt <= '0;
      else if (r_state != S_IDLE)  r_wd_cnt <= r_wd_cnt + 16'd1;
      if (w_abort) r_timeout_err <= 1'b1;
    end
  end

  // Fires on the TIMEOUT-th busy cycle so the flag is visible TIMEOUT cycles after entering ISSUE.
  assign w_timeout   = (r_state != S_IDLE) && (r_wd_cnt == 16'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_rw    = r_rw;
  assign mem_req_addr  = r_addr;
  assign mem_req_data  = r_data;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester/memory models advanced by cyc(), per-scenario tasks.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int LA = 8;
  localparam int LB = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_rw = '0;
  logic [N*LA-1:0] req_addr = '0;
  logic [N*LB-1:0] req_data = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic [LB-1:0]   resp_data;
  logic            mem_req_valid, mem_req_rw;
  logic [LA-1:0]   mem_req_addr;
  logic [LB-1:0]   mem_req_data;
  logic            mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [LB-1:0]   mem_resp_data = '0;
  logic            busy;
`ifdef MEM_ARB_WATCHDOG_EN
  logic            timeout_err;
`endif

  mem_port_arbiter #(
    .N_REQ(N), .LA_BITS(LA), .LINE_BITS(LB)
`ifdef MEM_ARB_WATCHDOG_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
`ifdef MEM_ARB_WATCHDOG_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            mem_mute, pend, force_resp;
  int            mem_stall, stall_cnt;
  logic [LB-1:0] pend_data;
  logic [LB-1:0] store [256];
  int            gnt_q[$], gnt_cyc_q[$];
  bit            acc_rw_q[$];
  logic [LB-1:0] acc_data_q[$];
  int            resp_cnt [N];
  int            resp_cyc [N];
  logic [LB-1:0] last_resp_data;
  int            bad_cnt, cyc_no;
  logic [N-1:0]  persist, gnt_seen;

  task automatic clear_logs();
    gnt_q.delete(); gnt_cyc_q.delete(); acc_rw_q.delete(); acc_data_q.delete();
    for (int i = 0; i < N; i++) begin resp_cnt[i] = 0; resp_cyc[i] = -1; end
    last_resp_data = '0;
    bad_cnt = 0;
  endtask

  // One clock: observe the current cycle, play memory, cross the edge, drop accepted requests.
  // Called and returns at a negedge.
  task automatic cyc();
    #1;
    if ($countones(req_ready) > 1 || $countones(resp_valid) > 1) bad_cnt++;
    gnt_seen = req_ready;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin gnt_q.push_back(i); gnt_cyc_q.push_back(cyc_no); end
      if (resp_valid[i]) begin resp_cnt[i]++; resp_cyc[i] = cyc_no; last_resp_data = resp_data; end
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (pend) begin mem_resp_valid = 1'b1; mem_resp_data = pend_data; pend = 1'b0; end
    if (force_resp) begin mem_resp_valid = 1'b1; mem_resp_data = 32'hBADC0DE5; force_resp = 1'b0; end
    mem_req_ready = 1'b0;
    if (mem_req_valid) begin
      if (stall_cnt < mem_stall) stall_cnt++;
      else begin
        mem_req_ready = 1'b1;
        stall_cnt = 0;
        acc_rw_q.push_back(mem_req_rw);
        acc_data_q.push_back(mem_req_data);
        if (mem_req_rw) store[mem_req_addr] = mem_req_data;
        pend_data = mem_req_rw ? '0 : store[mem_req_addr];
        pend = !mem_mute;
      end
    end
    @(posedge clk); #1;
    cyc_no++;
    for (int i = 0; i < N; i++)
      if (gnt_seen[i] && !persist[i]) req_valid[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0; req_rw = '0; persist = '0;
    mem_mute = 1'b0; mem_stall = 0; stall_cnt = 0; pend = 1'b0; force_resp = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    clear_logs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++;
    if ({resp_valid, resp_data, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rv=%b rd=%h mv=%b rw=%b ma=%h md=%h busy=%b exp all 0",
               resp_valid, resp_data, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, busy);
    end
    cyc();
    checks++;
    if ({req_ready, mem_req_valid, busy} !== '0) begin
      errors++; $display("FAIL reset_held got rr=%b mv=%b busy=%b exp 0", req_ready, mem_req_valid, busy);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    int g;
    do_reset();
    store[8'h1A] = 32'hDEADBEEF;
    req_rw[2] = 1'b0; req_addr[2*LA +: LA] = 8'h1A; req_valid[2] = 1'b1;
    cyc();
    g = (gnt_q.size() > 0) ? gnt_q[0] : -1;
    checks++;
    if (g !== 2) begin errors++; $display("FAIL rd_grant got %0d exp 2", g); end
    req_addr[2*LA +: LA] = 8'h33;
    checks++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr, busy} !== {1'b1, 1'b0, 8'h1A, 1'b1}) begin
      errors++; $display("FAIL rd_issue got v=%b rw=%b a=%h b=%b exp 1 0 1a 1", mem_req_valid, mem_req_rw, mem_req_addr, busy);
    end
    cyc();
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %b exp 0", mem_req_valid); end
    cyc();
    checks++;
    if ({resp_valid, resp_data} !== {4'b0100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_resp got %b %h exp 0100 deadbeef", resp_valid, resp_data);
    end
    cyc();
    checks++;
    if ({resp_valid, resp_data, busy} !== {4'b0000, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL rd_resp_end got %b %h busy=%b exp 0000 deadbeef 0", resp_valid, resp_data, busy);
    end
    checks++;
    if (gnt_q.size() !== 1) begin errors++; $display("FAIL rd_one_grant got %0d exp 1", gnt_q.size()); end
  endtask

  task automatic test_write_read();
    logic [1:0] rws;
    do_reset();
    req_rw[0] = 1'b1; req_addr[0 +: LA] = 8'h07; req_data[0 +: LB] = 32'h000055AA; req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && resp_cnt[0] < 1; k++) cyc();
    req_rw[0] = 1'b0; req_data[0 +: LB] = 32'hFFFF0000; req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && resp_cnt[0] < 2; k++) cyc();
    checks++;
    if (resp_cnt[0] !== 2) begin errors++; $display("FAIL wr_rd_resp_count got %0d exp 2", resp_cnt[0]); end
    rws = (acc_rw_q.size() == 2) ? {acc_rw_q[0], acc_rw_q[1]} : 2'bxx;
    checks++;
    if (rws !== 2'b10) begin errors++; $display("FAIL wr_rd_rw_order got %b exp 10", rws); end
    checks++;
    if (acc_data_q.size() == 0 || acc_data_q[0] !== 32'h000055AA) begin
      errors++; $display("FAIL wr_data got %h exp 000055aa", (acc_data_q.size() > 0) ? acc_data_q[0] : 'x);
    end
    checks++;
    if (last_resp_data !== 32'h000055AA) begin errors++; $display("FAIL rd_back got %h exp 000055aa", last_resp_data); end
  endtask

  task automatic test_all_four();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i*LA +: LA] = 8'(8'h10 + i);
      store[8'h10 + i] = 32'hA0 + i;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3] == 4) break;
    end
    for (int i = 0; i < N; i++) begin
      g = (i < gnt_q.size()) ? gnt_q[i] : -1;
      checks++;
      if (g !== i) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, g, i); end
    end
    checks++;
    if ({resp_cnt[0], resp_cnt[1], resp_cnt[2], resp_cnt[3]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL rr_resp_each got %0d %0d %0d %0d exp 1 1 1 1", resp_cnt[0], resp_cnt[1], resp_cnt[2], resp_cnt[3]);
    end
    checks++;
    if (bad_cnt !== 0) begin errors++; $display("FAIL onehot got %0d multi-bit cycles exp 0", bad_cnt); end
    clear_logs();
    req_valid = 4'b1001;
    cyc();
    g = (gnt_q.size() > 0) ? gnt_q[0] : -1;
    checks++;
    if (g !== 0) begin errors++; $display("FAIL rr_wrap got %0d exp 0", g); end
    for (int k = 0; k < 30 && resp_cnt[3] < 1; k++) cyc();
    g = (gnt_q.size() > 1) ? gnt_q[1] : -1;
    checks++;
    if (g !== 3) begin errors++; $display("FAIL rr_wrap_next got %0d exp 3", g); end
  endtask

  task automatic test_alternate();
    int g;
    do_reset();
    persist = 4'b1010;
    req_valid = 4'b1010;
    for (int k = 0; k < 60 && gnt_q.size() < 6; k++) cyc();
    for (int i = 0; i < 6; i++) begin
      g = (i < gnt_q.size()) ? gnt_q[i] : -1;
      checks++;
      if (g !== ((i % 2 == 0) ? 1 : 3)) begin
        errors++; $display("FAIL alt_grant[%0d] got %0d exp %0d", i, g, (i % 2 == 0) ? 1 : 3);
      end
    end
    persist = '0;
    req_valid = '0;
    for (int k = 0; k < 10; k++) cyc();
  endtask

  task automatic test_stall();
    do_reset();
    mem_stall = 5;
    req_rw[1] = 1'b1; req_addr[1*LA +: LA] = 8'h2B; req_data[1*LB +: LB] = 32'h12345678; req_valid[1] = 1'b1;
    cyc();
    req_rw[2] = 1'b0; req_addr[2*LA +: LA] = 8'h44; store[8'h44] = 32'h00000044; req_valid[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_data, req_ready} !== {1'b1, 8'h2B, 32'h12345678, 4'b0000}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b a=%h d=%h rr=%b exp 1 2b 12345678 0000",
                 k, mem_req_valid, mem_req_addr, mem_req_data, req_ready);
      end
      cyc();
    end
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", mem_req_valid); end
    checks++;
    if (gnt_q.size() !== 1) begin errors++; $display("FAIL stall_one_grant got %0d exp 1", gnt_q.size()); end
    mem_stall = 0;
    for (int k = 0; k < 40 && resp_cnt[2] < 1; k++) cyc();
    checks++;
    if ({resp_cnt[1], resp_cnt[2], last_resp_data} !== {32'd1, 32'd1, 32'h00000044}) begin
      errors++; $display("FAIL stall_resps got %0d %0d %h exp 1 1 00000044", resp_cnt[1], resp_cnt[2], last_resp_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_mute = 1'b1;
    store[8'h3C] = 32'hCAFEF00D;
    req_rw[3] = 1'b0; req_addr[3*LA +: LA] = 8'h3C; req_valid[3] = 1'b1;
    cyc(); cyc();
    checks++;
    if ({busy, mem_req_valid} !== 2'b10) begin
      errors++; $display("FAIL mid_wait_state got busy=%b v=%b exp 1 0", busy, mem_req_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_data, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, busy} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got rv=%b rd=%h mv=%b ma=%h busy=%b exp all 0",
                         resp_valid, resp_data, mem_req_valid, mem_req_addr, busy);
    end
    cyc();
    reset_n = 1'b1;
    mem_mute = 1'b0;
    force_resp = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if (resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3] !== 0) begin
      errors++; $display("FAIL stray_ignored got %0d resp pulses exp 0", resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3]);
    end
    checks++;
    if ({busy, mem_req_valid, resp_valid, resp_data} !== '0) begin
      errors++; $display("FAIL post_reset_idle got busy=%b v=%b rv=%b rd=%h exp 0", busy, mem_req_valid, resp_valid, resp_data);
    end
  endtask

  task automatic test_back_to_back();
    int gap, ovl, lat;
    do_reset();
    store[8'h50] = 32'h00000001; store[8'h60] = 32'h00000002;
    req_addr[0 +: LA] = 8'h50; req_addr[2*LA +: LA] = 8'h60;
    req_rw = '0;
    req_valid = 4'b0101;
    for (int k = 0; k < 40 && resp_cnt[2] < 1; k++) cyc();
    gap = (gnt_cyc_q.size() == 2) ? gnt_cyc_q[1] - gnt_cyc_q[0] : -1;
    ovl = (gnt_cyc_q.size() == 2) ? resp_cyc[0] - gnt_cyc_q[1] : -1;
    lat = (gnt_cyc_q.size() == 2) ? resp_cyc[2] - gnt_cyc_q[1] : -1;
    checks++;
    if (gap !== 3) begin errors++; $display("FAIL b2b_gap got %0d exp 3", gap); end
    checks++;
    if (ovl !== 0) begin errors++; $display("FAIL b2b_overlap got %0d exp 0", ovl); end
    checks++;
    if ({lat, last_resp_data} !== {32'd3, 32'h00000002}) begin
      errors++; $display("FAIL b2b_latency got %0d %h exp 3 00000002", lat, last_resp_data);
    end
  endtask

`ifdef MEM_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    mem_mute = 1'b1;
    req_rw[1] = 1'b0; req_addr[1*LA +: LA] = 8'h77; req_valid[1] = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({timeout_err, resp_valid} !== 5'b0) begin
        errors++; $display("FAIL wd_quiet[%0d] got err=%b rv=%b exp 0", k, timeout_err, resp_valid);
      end
      cyc();
    end
    checks++;
    if ({timeout_err, resp_valid, resp_data, busy} !== {1'b1, 4'b0010, 32'h0, 1'b0}) begin
      errors++; $display("FAIL wd_fire got err=%b rv=%b rd=%h busy=%b exp 1 0010 0 0", timeout_err, resp_valid, resp_data, busy);
    end
    mem_mute = 1'b0;
    store[8'h1A] = 32'hDEADBEEF;
    req_addr[2*LA +: LA] = 8'h1A; req_valid[2] = 1'b1;
    for (int k = 0; k < 20 && resp_cnt[2] < 1; k++) cyc();
    checks++;
    if ({resp_cnt[2], last_resp_data, timeout_err} !== {32'd1, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL wd_recover got %0d %h err=%b exp 1 deadbeef 1", resp_cnt[2], last_resp_data, timeout_err);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) store[i] = '0;
    cyc_no = 0;
    persist = '0;
    clear_logs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_read();
    test_all_four();
    test_alternate();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish before 200000");
    $fatal(1);
  end

endmodule
